ifft_output_reorder: RTL and testbench
======================================

// Module: ifft_output_reorder
// PURPOSE
//  Final block of the 64-point SDF mixed-radix IFFT, directly downstream of the last butterfly stage.
//  The last stage delivers one complex sample per cycle in bit-reversed order; this block restores natural order.
//  It uses a ping-pong buffer (2 banks x NFFT complex words).
//  It emits a continuous natural-order stream with valid, first and last flags.
// PARAMETERS
//  INTEGER_SIZE  6    integer bits of signed fixed-point sample
//  FRACT_SIZE    12   fraction bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE (18)
//  NFFT          64   frame length, power of two >= 4; LOG2N = $clog2(NFFT)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           asynchronous active-low reset
//  start_conv    in   1           1-cycle pulse; marks the cycle carrying sample 0 of the first frame
//  serial_in_r   in   DATA_WIDTH  signed real part of the bit-reversed input sample
//  serial_in_i   in   DATA_WIDTH  signed imag part of the bit-reversed input sample
//  out_r         out  DATA_WIDTH  signed real part of the natural-order sample
//  out_i         out  DATA_WIDTH  signed imag part of the natural-order sample
//  out_valid     out  1           out_r/out_i hold a valid sample
//  out_first     out  1           valid sample is index 0 of a frame
//  out_last      out  1           valid sample is index NFFT-1 of a frame
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, state IDLE, wr_cnt=0, wr_bank=0.
//  Stream model:
//   - No input valid. From start_conv onward, every cycle carries one sample.
//   - Frames are back-to-back with no gaps.
//  Write side:
//   - wr_cnt counts 0..NFFT-1 and wraps.
//   - Each cycle, sample is written to bank wr_bank at address bitrev(wr_cnt) over LOG2N bits.
//   - When wr_cnt wraps from NFFT-1 to 0, wr_bank toggles.
//  Read side:
//   - rd_cnt runs in lockstep with wr_cnt.
//   - Each cycle, bank ~wr_bank is read at address rd_cnt; outputs are registered.
//  FSM:
//   - IDLE: write disabled, out_valid=0. start_conv -> FILL; that cycle's sample is written as wr_cnt=0.
//   - FILL: writes only, out_valid=0. When wr_cnt=NFFT-1 is written -> STREAM.
//   - STREAM: simultaneous write and read. out_valid=1 every cycle.
//  Latency: frame sample 0 enters at cycle T -> natural index 0 appears on out_r/out_i with out_valid=1 at T+NFFT+1.
//  out_first=1 when the registered index is 0; out_last=1 when it is NFFT-1. Both are 0 whenever out_valid=0.
//  Bank wrap: read of the old bank and write of the new bank never hit the same bank in one cycle. No bypass required.
//  start_conv while in FILL or STREAM (restart):
//   - Current partial frame is discarded.
//   - That cycle's sample becomes index 0: wr_cnt=0, wr_bank unchanged, state -> FILL.
//   - out_valid drops to 0 the following cycle; no partial output frame is emitted.
//  start_conv coinciding with the wr_cnt wrap: restart wins; no bank toggle and no STREAM entry.
//  Reset mid-frame: everything returns to the reset state immediately. Buffer contents need not be cleared.
//  Input values pass through unmodified unless the CONFIGURATION macro is defined.
// CONFIGURATION
//  IFFT_OUT_SCALE_EN defined:
//   - Each output component = round(x / NFFT) = (x + 2^(LOG2N-1)) >>> LOG2N.
//   - Computed in DATA_WIDTH+1 bits, so there is no overflow.
//   - Result is sign-extended back to DATA_WIDTH.
//   - The scaler is applied in the output register stage; latency is unchanged.
//  IFFT_OUT_SCALE_EN undefined:
//   - Output = stored sample unchanged. The 1/N factor is left to downstream logic.
// TESTING
//  T1 bitrev map:
//   - Stimulus: after start_conv, input serial_in_r = wr_cnt (0..63), serial_in_i = -wr_cnt.
//   - Required: out_r = bitrev6(k) at output index k, e.g. idx1 -> 32, idx2 -> 16, idx63 -> 63. out_i = -out_r.
//  T2 latency/flags:
//   - Stimulus: start_conv at cycle T.
//   - Required: out_valid 0 until T+65. At T+65, out_valid=1 and out_first=1. At T+128, out_last=1.
//  T3 back-to-back:
//   - Stimulus: 4 consecutive frames, each filled with a distinct constant (100, 200, 300, 400).
//   - Required: 256 contiguous valid outputs in frame order with no gap. out_first every 64 cycles.
//  T4 restart:
//   - Stimulus: start_conv again at wr_cnt=20 of frame 2.
//   - Required: out_valid=0 on the next cycle. The new frame's index 0 appears 65 cycles after the restart pulse.
//  T5 reset mid-STREAM:
//   - Stimulus: pull rst low asynchronously between clock edges.
//   - Required: outputs 0 immediately; no output until the next start_conv plus 65 cycles.
//  T6 scaling (IFFT_OUT_SCALE_EN):
//   - Inputs 64, 32, -32, -33, 131071.
//   - Required outputs: 1, 1, 0, -1, 2048.

Source files
------------

// File: rtl/ifft_output_reorder.sv
// ---------------------------------------------------------------------------
// ifft_output_reorder
//
// Final stage of the 64-point SDF mixed-radix IFFT. The last butterfly stage
// produces one complex sample per cycle in bit-reversed order. This block
// turns that stream back into natural order using a two-bank ping-pong
// buffer of NFFT complex words. While one bank is being written with the
// incoming frame, the other bank is read out in natural order.
//
// Optional feature (compile-time macro):
//   IFFT_OUT_SCALE_EN - when defined, each output component is divided by
//                       NFFT with round-half-up: (x + NFFT/2) >>> LOG2N.
//                       When undefined, samples pass through unchanged.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   start_conv   in   1-cycle pulse on the cycle carrying sample 0 of a frame;
//                     also restarts the frame if asserted mid-stream
//   serial_in_r  in   signed real part of the bit-reversed input sample
//   serial_in_i  in   signed imaginary part of the bit-reversed input sample
//   out_r        out  signed real part of the natural-order output sample
//   out_i        out  signed imaginary part of the natural-order output sample
//   out_valid    out  out_r/out_i carry a valid sample
//   out_first    out  valid sample is natural index 0 of its frame
//   out_last     out  valid sample is natural index NFFT-1 of its frame
// ---------------------------------------------------------------------------
module ifft_output_reorder #(
    parameter  int INTEGER_SIZE = 6,
    parameter  int FRACT_SIZE   = 12,
    parameter  int NFFT         = 64,
    localparam int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE,
    localparam int LOG2N        = $clog2(NFFT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_conv,
    input  logic signed [DATA_WIDTH-1:0] serial_in_r,
    input  logic signed [DATA_WIDTH-1:0] serial_in_i,
    output logic signed [DATA_WIDTH-1:0] out_r,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic                         out_valid,
    output logic                         out_first,
    output logic                         out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

`ifdef IFFT_OUT_SCALE_EN
    localparam logic signed [DATA_WIDTH:0] ROUND_C = (DATA_WIDTH+1)'(NFFT / 2);

    // One guard bit keeps x + NFFT/2 from overflowing before the shift.
    function automatic logic signed [DATA_WIDTH-1:0] scale_f(
        input logic signed [DATA_WIDTH-1:0] x
    );
        logic signed [DATA_WIDTH:0] ext;
        logic signed [DATA_WIDTH:0] shr;
        ext = $signed({x[DATA_WIDTH-1], x}) + ROUND_C;
        shr = ext >>> LOG2N;
        return shr[DATA_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [DATA_WIDTH-1:0] scale_f(
        input logic signed [DATA_WIDTH-1:0] x
    );
        return x;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                         state_q,     state_d;
    logic [LOG2N-1:0]               wr_cnt_q,    wr_cnt_d;
    logic                           wr_bank_q,   wr_bank_d;
    logic signed [DATA_WIDTH-1:0]   out_r_q,     out_r_d;
    logic signed [DATA_WIDTH-1:0]   out_i_q,     out_i_d;
    logic                           out_valid_q, out_valid_d;
    logic                           out_first_q, out_first_d;
    logic                           out_last_q,  out_last_d;

    // Ping-pong buffer: {real, imag} per word. Not reset; contents are
    // always overwritten before they are read.
    logic [2*DATA_WIDTH-1:0]        buf_q [2][NFFT];

    logic                           wr_en;
    logic [LOG2N-1:0]               wr_addr;
    logic                           rd_en;
    logic                           rd_bank;
    logic [2*DATA_WIDTH-1:0]        rd_word;

    // ------------------------------------------------------------------
    // Write / read control
    // ------------------------------------------------------------------
    always_comb begin
        // A start pulse forces the current sample to index 0 whatever the
        // counter holds, so restart and first start share one path.
        wr_en   = start_conv || (state_q != S_IDLE);
        wr_addr = start_conv ? bitrev('0) : bitrev(wr_cnt_q);

        // Read address tracks the write counter; the read bank is always
        // the one not being written, so the two never collide.
        rd_en   = (state_q == S_STREAM) && !start_conv;
        rd_bank = ~wr_bank_q;
        rd_word = buf_q[rd_bank][wr_cnt_q];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_bank_q][wr_addr] <= {serial_in_r, serial_in_i};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;

        if (start_conv) begin
            // Restart wins over a coincident wrap: the bank is kept and
            // the partially written frame is simply overwritten.
            state_d  = S_FILL;
            wr_cnt_d = LOG2N'(1);
        end else if (state_q != S_IDLE) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (wr_cnt_q == '1) begin
                wr_bank_d = ~wr_bank_q;
                state_d   = S_STREAM;
            end
        end

        out_valid_d = rd_en;
        out_first_d = rd_en && (wr_cnt_q == '0);
        out_last_d  = rd_en && (wr_cnt_q == '1);
        out_r_d     = '0;
        out_i_d     = '0;
        if (rd_en) begin
            out_r_d = scale_f(rd_word[2*DATA_WIDTH-1:DATA_WIDTH]);
            out_i_d = scale_f(rd_word[DATA_WIDTH-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ifft_output_reorder.sv
// ---------------------------------------------------------------------------
// tb_ifft_output_reorder
//
// Bench for ifft_output_reorder. A frame-level reference model predicts every
// output cycle: a completed input frame (in arrival order) is replayed while
// the next frame arrives, natural index k taking the sample that arrived at
// position bitrev(k). Directed sequences cover the bit-reverse map, latency
// and flags, back-to-back frames, restart, async reset, restart on the wrap
// cycle and the output scaler; a random phase follows.
// ---------------------------------------------------------------------------
module tb_ifft_output_reorder;

    localparam int DW = 18;
    localparam int N  = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start_conv = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] out_r, out_i;
    logic                 out_valid, out_first, out_last;

    ifft_output_reorder #(
        .INTEGER_SIZE(6),
        .FRACT_SIZE  (12),
        .NFFT        (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_conv (start_conv),
        .serial_in_r(in_r),
        .serial_in_i(in_i),
        .out_r      (out_r),
        .out_i      (out_i),
        .out_valid  (out_valid),
        .out_first  (out_first),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "reset";

    // ---------------- reference model ----------------
    bit m_active, m_have_prev;
    int m_cnt;
    int cur_r[N], cur_i[N], prev_r[N], prev_i[N];
    bit e_valid, e_first, e_last;
    int e_r, e_i;

    function automatic int bitrev(input int v);
        int r = 0;
        int n = v;
        for (int b = 0; b < 6; b++) begin
            r = r * 2 + (n % 2);
            n = n / 2;
        end
        return r;
    endfunction

    // round(x / N), halves rounded toward +infinity
    function automatic int scl(input int x);
`ifdef IFFT_OUT_SCALE_EN
        int v = x + N / 2;
        int q = v / N;
        if (v < 0 && q * N != v) q = q - 1;
        return q;
`else
        return x;
`endif
    endfunction

    function automatic int rnd18();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return int'(t);
    endfunction

    task automatic model_reset();
        m_active = 0; m_have_prev = 0; m_cnt = 0;
        e_valid = 0; e_first = 0; e_last = 0; e_r = 0; e_i = 0;
    endtask

    task automatic model_step(input bit st, input int xr, input int xi);
        if (m_have_prev && !st) begin
            e_valid = 1;
            e_first = (m_cnt == 0);
            e_last  = (m_cnt == N - 1);
            e_r     = scl(prev_r[bitrev(m_cnt)]);
            e_i     = scl(prev_i[bitrev(m_cnt)]);
        end else begin
            e_valid = 0; e_first = 0; e_last = 0; e_r = 0; e_i = 0;
        end
        if (st) begin
            m_active = 1; m_have_prev = 0; m_cnt = 0;
        end
        if (m_active) begin
            cur_r[m_cnt] = xr;
            cur_i[m_cnt] = xi;
            m_cnt++;
            if (m_cnt == N) begin
                prev_r = cur_r;
                prev_i = cur_i;
                m_have_prev = 1;
                m_cnt = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_out();
        n_checks++;
        if (out_valid !== e_valid || out_first !== e_first || out_last !== e_last ||
            int'(out_r) != e_r || int'(out_i) != e_i) begin
            n_fail++;
            $display("FAIL %s @%0t: got v=%0b f=%0b l=%0b r=%0d i=%0d, expected v=%0b f=%0b l=%0b r=%0d i=%0d",
                     phase, $time, out_valid, out_first, out_last, out_r, out_i,
                     e_valid, e_first, e_last, e_r, e_i);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, clock, sample #1 later, compare to model.
    task automatic cyc(input bit st, input int xr, input int xi);
        start_conv = st;
        in_r = DW'(xr);
        in_i = DW'(xi);
        @(posedge clk);
        #1;
        model_step(st, xr, xi);
        check_out();
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        int k;      // natural output index
        int exp_r;  // raw expected real part for the T1 ramp
    } map_vec_t;

    typedef struct {
        int in_v;   // raw input value
        int exp_s;  // expected output with scaling enabled
    } scl_vec_t;

    map_vec_t map_tbl[6];
    scl_vec_t scl_tbl[5];
    int cap_r[N], cap_i[N];
    int first_c, last_c, cnt_a, cnt_b;
    bit st;
    int xr;

    initial begin
        map_tbl = '{'{0, 0}, '{1, 32}, '{2, 16}, '{3, 48}, '{62, 31}, '{63, 63}};
        scl_tbl = '{'{64, 1}, '{32, 1}, '{-32, 0}, '{-33, -1}, '{131071, 2048}};
        model_reset();

        // Reset state
        #2;
        check_out();
        #5 rst = 1'b1;
        phase = "idle";
        for (int c = 0; c < 3; c++) cyc(0, rnd18(), rnd18());

        // T1 / T2: ramp frame, latency and flags
        phase = "T1T2";
        first_c = -1; last_c = -1;
        for (int c = 0; c < 192; c++) begin
            if (c < N) cyc(c == 0, c, -c);
            else       cyc(0, rnd18(), rnd18());
            if (out_valid && first_c < 0) first_c = c;
            if (out_last && last_c < 0)   last_c = c;
            if (c == 64) chk("T2 out_first at T+65", int'(out_first), 1);
            if (c >= N && c < 2 * N) begin
                cap_r[c - N] = int'(out_r);
                cap_i[c - N] = int'(out_i);
            end
        end
        chk("T2 first valid offset", first_c, 64);
        chk("T2 first last offset", last_c, 127);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("T1 map r idx%0d", map_tbl[j].k), cap_r[map_tbl[j].k], scl(map_tbl[j].exp_r));
            chk($sformatf("T1 map i idx%0d", map_tbl[j].k), cap_i[map_tbl[j].k], scl(-map_tbl[j].exp_r));
        end

        // T3: four constant frames back to back (restart from STREAM)
        phase = "T3";
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 5 * N; c++) begin
            if (c < 4 * N) cyc(c == 0, 100 * (c / N + 1), -(100 * (c / N + 1)));
            else           cyc(0, rnd18(), rnd18());
            if (c >= N && out_valid && int'(out_r) == scl(100 * ((c - N) / N + 1))) cnt_a++;
            if (out_first) cnt_b++;
        end
        chk("T3 contiguous valid outputs", cnt_a, 256);
        chk("T3 out_first count", cnt_b, 4);

        // T4: restart at wr_cnt=20 while streaming
        phase = "T4";
        for (int c = 0; c < 20; c++) cyc(0, rnd18(), rnd18());
        cyc(1, rnd18(), rnd18());
        chk("T4 valid drops after restart", int'(out_valid), 0);
        first_c = -1;
        for (int c = 1; c < 140; c++) begin
            cyc(0, rnd18(), rnd18());
            if (out_valid && first_c < 0) first_c = c;
        end
        chk("T4 restart latency", first_c, 64);

        // T5: async reset mid-STREAM
        phase = "T5";
        #3 rst = 1'b0;
        #1;
        chk("T5 async reset outputs", int'({out_valid, out_first, out_last}) + int'(out_r != 0) + int'(out_i != 0), 0);
        model_reset();
        #2 rst = 1'b1;
        for (int c = 0; c < 10; c++) cyc(0, rnd18(), rnd18());

        // T6: scaler vectors placed at arrival positions 0..4
        phase = "T6";
        first_c = -1;
        for (int c = 0; c < 2 * N; c++) begin
            xr = (c < 5) ? scl_tbl[c].in_v : 0;
            cyc(c == 0, xr, -xr);
            if (out_valid && first_c < 0) first_c = c;
            if (c >= N) begin
                cap_r[c - N] = int'(out_r);
                cap_i[c - N] = int'(out_i);
            end
        end
        chk("T5 latency after reset", first_c, 64);
        for (int j = 0; j < 5; j++) begin
`ifdef IFFT_OUT_SCALE_EN
            chk($sformatf("T6 scale r in=%0d", scl_tbl[j].in_v), cap_r[bitrev(j)], scl_tbl[j].exp_s);
`else
            chk($sformatf("T6 pass r in=%0d", scl_tbl[j].in_v), cap_r[bitrev(j)], scl_tbl[j].in_v);
`endif
            chk($sformatf("T6 i in=%0d", scl_tbl[j].in_v), cap_i[bitrev(j)], scl(-scl_tbl[j].in_v));
        end

        // Restart on the wrap cycle (position 63 of a streaming frame)
        phase = "wrap_restart";
        for (int c = 0; c < N + 2; c++) begin
            st = m_have_prev && (m_cnt == N - 1);
            cyc(st, rnd18(), rnd18());
            if (st) break;
        end
        chk("wrap restart valid drop", int'(out_valid), 0);
        for (int c = 0; c < 2 * N; c++) cyc(0, rnd18(), rnd18());

        // Random phase
        phase = "random";
        for (int c = 0; c < 800; c++) cyc($urandom_range(0, 99) == 0, rnd18(), rnd18());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
